dma_req_arbiter: RTL and testbench
==================================

# dma_req_arbiter

Round-robin arbiter and pre-filter that shares the single DMA master port between two requesters. Each requester asks for a burst of consecutive word accesses. The block sequences the burst onto `dma_addr`/`dma_en`. It rejects any burst that would touch the protected X-stack region (SDATA) or the CTR region, so a legitimate requester never trips the ROT DMA monitor. It sits between the requesters and the memory/monitor DMA port, and aborts all activity while the ROT reset is asserted.

## Interface
Parameters:
- `SDATA_BASE`, 16'hB00: protected X-stack region base.
- `SDATA_SIZE`, 16'hC00: region size; the region is [BASE, BASE+SIZE).
- `CTR_BASE`, 16'hFFC0: protected CTR region base.
- `CTR_SIZE`, 16'h001F: region size; the region is [BASE, BASE+SIZE).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `rot_reset`  in  1  ROT monitor reset; abort and block while high.
- `req0` / `req1`  in  1  request, held until `done`/`err` pulse.
- `addr0` / `addr1`  in  16  burst start word address.
- `len0` / `len1`  in  4  burst length in words; 0 is illegal.
- `gnt0` / `gnt1`  out  1  high while that requester's burst is on the port.
- `done0` / `done1`  out  1  one-cycle pulse when the burst completes.
- `err0` / `err1`  out  1  one-cycle pulse when the burst is rejected.
- `dma_addr`  out  16  DMA address.
- `dma_en`  out  1  DMA access valid.
- `dma_ready`  in  1  memory accepts the current word this cycle.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, round-robin pointer favouring requester 0.
- States:
  - IDLE: arbitrate among pending requests.
  - XFER: issue words of the granted burst.
  - RESP: one cycle, pulses `done` or `err`, then returns to IDLE.
- Arbitration, in IDLE with `rot_reset`=0:
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester favoured by the pointer wins.
  - The pointer flips to favour the other requester after every RESP, whether done or err.
- On a win, the block latches `addr`/`len` of the winner; the inputs are not sampled again during that burst. It then computes last = addr + len - 1 in 17 bits.
- A burst is rejected (IDLE → RESP with `err`, `dma_en` never asserted) if any of these holds:
  - len == 0;
  - last > 16'hFFFF (wrap-around);
  - addr < SDATA_BASE+SDATA_SIZE and last >= SDATA_BASE;
  - addr < CTR_BASE+CTR_SIZE and last >= CTR_BASE.
- Region bounds are computed in 17 bits.
- Otherwise IDLE → XFER:
  - `gnt_i`=1, `dma_en`=1, `dma_addr`=addr.
  - Each cycle with `dma_ready`=1 increments `dma_addr` and decrements the remaining count.
  - When `dma_ready` is low, `dma_addr`/`dma_en` hold.
  - Acceptance of the last word moves the block to RESP: `dma_en`=0, `gnt_i`=0, `done_i`=1 for one cycle.
- `rot_reset`=1 in any state:
  - next state IDLE;
  - `dma_en`, `gnt*`, `done*` and `err*` are 0 next cycle;
  - no `done` pulse for the aborted burst; the pointer is unchanged.
  - While `rot_reset` stays high, no grant is issued.
  - Requesters must re-request after an abort.
- A request that drops mid-burst is ignored; the burst completes.

## Timing
- `req` sampled high in IDLE at edge t → at t+1 either XFER (`gnt`, `dma_en`, `dma_addr` valid) or RESP (`err` pulse).
- N-word burst with `dma_ready` held high: `dma_en` high for N cycles, `done` pulses in the cycle after, IDLE the cycle after that. The earliest next grant is 2 cycles after the last word.
- `done`/`err` are exactly one cycle wide and mutually exclusive. At most one of `gnt0`/`gnt1` is high.
- `rot_reset` rising at edge t → `dma_en`=0 from t+1.

## Test plan
- req0, addr0=16'h0200, len0=3, `dma_ready`=1 → `dma_addr` 0x0200, 0x0201, 0x0202 on consecutive cycles with `gnt0`=1. Then `done0` pulses once; `err0` stays 0.
- req0 and req1 held together after reset, each len=1 → grant order 0, 1, 0, 1. `gnt0` and `gnt1` are never high together.
- req1 addr1=16'h0AFE len1=4 → `err1` pulse one cycle after the request, `dma_en` stays 0. Then addr1=16'h0AFC len1=4 → accepted, last address 0x0AFF.
- CTR and wrap boundaries:
  - addr=16'hFFDF len=1 → accepted;
  - addr=16'hFFDE len=2 → err;
  - addr=16'hFFFE len=3 → err (wrap);
  - len=0 → err.
- addr=16'h0300 len=4 with `dma_ready` low for 2 cycles on the second word → `dma_addr` holds 0x0301 and `dma_en` holds 1. `done` arrives 2 cycles later than the no-stall case.
- `rot_reset` pulsed high during word 2 of a len=5 burst → `dma_en`=0 the next cycle, no `done`. No grant while `rot_reset` is high. A fresh request after it falls is served normally.

Source files
------------

// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter: two-requester round-robin front end for the shared DMA
// master port. Bursts that would touch SDATA or CTR, that wrap past 16'hFFFF
// or that have zero length are refused with an err pulse before any access.
module dma_req_arbiter #(
  parameter logic [15:0] SDATA_BASE = 16'hB00,
  parameter logic [15:0] SDATA_SIZE = 16'hC00,
  parameter logic [15:0] CTR_BASE   = 16'hFFC0,
  parameter logic [15:0] CTR_SIZE   = 16'h001F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rot_reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  input  logic        dma_ready
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  // Region ends are one past the last protected word, widened so BASE+SIZE
  // cannot overflow.
  localparam logic [16:0] SDATA_END = {1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE};
  localparam logic [16:0] CTR_END   = {1'b0, CTR_BASE} + {1'b0, CTR_SIZE};

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;   // 0 favours requester 0 on a tie
  logic        cur_q, cur_d;   // requester owning the current burst
  logic [3:0]  rem_q, rem_d;   // words still to be accepted
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        dma_en_q, dma_en_d;
  logic [15:0] dma_addr_q, dma_addr_d;

  logic        win;
  logic [15:0] w_addr;
  logic [3:0]  w_len;
  logic [16:0] w_last;
  logic        w_bad;

  // Pick the winner and screen its burst against the protected regions.
  always_comb begin
    win    = (req0 && req1) ? ptr_q : req1;
    w_addr = win ? addr1 : addr0;
    w_len  = win ? len1 : len0;
    w_last = {1'b0, w_addr} + {13'b0, w_len} - 17'd1;
    w_bad  = (w_len == 4'd0)
          || w_last[16]
          || (({1'b0, w_addr} < SDATA_END) && (w_last >= {1'b0, SDATA_BASE}))
          || (({1'b0, w_addr} < CTR_END)   && (w_last >= {1'b0, CTR_BASE}));
  end

  // Next-state and registered-output logic; rot_reset overrides everything.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    dma_en_d   = dma_en_q;
    dma_addr_d = dma_addr_q;
    if (rot_reset) begin
      state_d  = IDLE;
      gnt_d    = 2'b00;
      dma_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            cur_d = win;
            if (w_bad) begin
              state_d = RESP;
              err_d   = win ? 2'b10 : 2'b01;
            end else begin
              state_d    = XFER;
              gnt_d      = win ? 2'b10 : 2'b01;
              dma_en_d   = 1'b1;
              dma_addr_d = w_addr;
              rem_d      = w_len;
            end
          end
        end
        XFER: begin
          if (dma_ready) begin
            if (rem_q == 4'd1) begin
              state_d  = RESP;
              gnt_d    = 2'b00;
              dma_en_d = 1'b0;
              done_d   = cur_q ? 2'b10 : 2'b01;
            end else begin
              dma_addr_d = dma_addr_q + 16'd1;
              rem_d      = rem_q - 4'd1;
            end
          end
        end
        RESP: begin
          state_d = IDLE;
          ptr_d   = ~ptr_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cur_q      <= 1'b0;
      rem_q      <= 4'd0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      dma_en_q   <= 1'b0;
      dma_addr_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dma_en_q   <= dma_en_d;
      dma_addr_q <= dma_addr_d;
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign dma_en   = dma_en_q;
  assign dma_addr = dma_addr_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: bursts, round-robin order, region and
// wrap rejection, ready stalls and rot_reset abort.
module tb_dma_req_arbiter;
  logic        clk = 1'b0;
  logic        reset_n, rot_reset;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic [3:0]  len0, len1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] dma_addr;
  logic        dma_en, dma_ready;

  int n_chk = 0;
  int n_pass = 0;

  dma_req_arbiter dut (
    .clk(clk), .reset_n(reset_n), .rot_reset(rot_reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .dma_addr(dma_addr), .dma_en(dma_en), .dma_ready(dma_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rot_reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0; dma_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_outs", {gnt0, gnt1, done0, done1, err0, err1, dma_en}, 7'd0);
    chk("rst_addr", dma_addr, 16'h0);
  endtask

  // One request from IDLE with dma_ready high; expect either a full burst or
  // an immediate err pulse. Leaves the block back in IDLE.
  task automatic burst(input string tag, input bit id, input logic [15:0] a,
                       input logic [3:0] l, input bit exp_err);
    if (id) begin req1 = 1'b1; addr1 = a; len1 = l; end
    else    begin req0 = 1'b1; addr0 = a; len0 = l; end
    tick();
    if (exp_err) begin
      chk({tag, "_err"}, {err1, err0}, id ? 2'b10 : 2'b01);
      chk({tag, "_noen"}, {dma_en, gnt1, gnt0, done1, done0}, 5'd0);
    end else begin
      for (int i = 0; i < l; i++) begin
        chk({tag, "_addr"}, dma_addr, a + 16'(i));
        chk({tag, "_gnt"}, {dma_en, gnt1, gnt0}, id ? 3'b110 : 3'b101);
        tick();
      end
      chk({tag, "_done"}, {done1, done0, err1, err0}, id ? 4'b1000 : 4'b0100);
      chk({tag, "_idle"}, {dma_en, gnt1, gnt0}, 3'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk({tag, "_pulse1"}, {done1, done0, err1, err0}, 4'd0);
  endtask

  initial begin
    bit got_g, seen;
    do_reset();

    // Basic three-word burst from requester 0.
    burst("b0", 1'b0, 16'h0200, 4'd3, 1'b0);

    // Both requesters held: expect alternating grants starting with 0.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0020;
    len0 = 4'd1; len1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0; got_g = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        tick();
        chk("rr_excl", {31'd0, gnt0 & gnt1}, 32'd0);
        if (gnt0 | gnt1) begin seen = 1'b1; got_g = gnt1; end
      end
      chk("rr_seen", {31'd0, seen}, 32'd1);
      chk("rr_order", {31'd0, got_g}, {31'd0, 1'(k % 2)});
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // Straddles SDATA base, then ends just below it.
    burst("sd_bad", 1'b1, 16'h0AFE, 4'd4, 1'b1);
    burst("sd_ok",  1'b1, 16'h0AFC, 4'd4, 1'b0);

    // CTR, wrap and zero-length boundaries.
    burst("ctr_ok",  1'b0, 16'hFFDF, 4'd1, 1'b0);
    burst("ctr_bad", 1'b0, 16'hFFDE, 4'd2, 1'b1);
    burst("wrap",    1'b0, 16'hFFFE, 4'd3, 1'b1);
    burst("len0",    1'b0, 16'h0100, 4'd0, 1'b1);

    // Two-cycle stall on the second word: done on the 7th edge, not the 5th.
    req0 = 1'b1; addr0 = 16'h0300; len0 = 4'd4; dma_ready = 1'b1;
    tick();
    chk("st_w0", dma_addr, 16'h0300);
    tick();
    chk("st_w1", dma_addr, 16'h0301);
    dma_ready = 1'b0;
    tick();
    chk("st_hold1", {15'd0, dma_en, dma_addr}, {15'd1, 16'h0301});
    tick();
    chk("st_hold2", {15'd0, dma_en, dma_addr}, {15'd1, 16'h0301});
    chk("st_nodone", {30'd0, done1, done0}, 32'd0);
    dma_ready = 1'b1;
    tick();
    chk("st_w2", dma_addr, 16'h0302);
    tick();
    chk("st_w3", dma_addr, 16'h0303);
    tick();
    chk("st_done", {30'd0, done1, done0}, 32'd1);
    req0 = 1'b0;
    tick();

    // rot_reset abort during word 2 of a five-word burst.
    req0 = 1'b1; addr0 = 16'h0400; len0 = 4'd5;
    tick();
    chk("ab_w0", dma_addr, 16'h0400);
    tick();
    chk("ab_w1", {15'd0, dma_en, dma_addr}, {15'd1, 16'h0401});
    rot_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ab_block", {gnt1, gnt0, dma_en, done1, done0, err1, err0}, 7'd0);
    end
    rot_reset = 1'b0; req0 = 1'b0;
    tick();
    chk("ab_quiet", {gnt1, gnt0, dma_en, done1, done0}, 5'd0);
    burst("ab_fresh", 1'b0, 16'h0500, 4'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
